// File: rtl/lsu_bus_bridge_pkg.sv
// Shared definitions for the load/store bus bridge.
//   - memop (func3) encodings for the supported access sizes
//   - FSM state type for the bridge controller
//   - memop_legal(): whether a func3 code is a valid load or store
package lsu_bus_bridge_pkg;

  localparam logic [2:0] MEM_OP_B  = 3'b000;
  localparam logic [2:0] MEM_OP_H  = 3'b001;
  localparam logic [2:0] MEM_OP_W  = 3'b010;
  localparam logic [2:0] MEM_OP_BU = 3'b100;
  localparam logic [2:0] MEM_OP_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_REQ  = 2'b01,
    ST_DONE = 2'b10
  } lsu_state_e;

  // Unsigned variants only exist for loads; stores accept B/H/W only.
  function automatic logic memop_legal(input logic [2:0] op, input logic is_store);
    logic ok;
    case (op)
      MEM_OP_B, MEM_OP_H, MEM_OP_W: ok = 1'b1;
      MEM_OP_BU, MEM_OP_HU:         ok = ~is_store;
      default:                      ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/lsu_data_align.sv
// Combinational lane logic for the load/store bus bridge.
// Store side works on the live request; load side works on the copy latched
// at request time so the result does not depend on inputs that moved during REQ.
// Ports:
//   i_addr_lo     in  2   byte offset of the live request
//   i_size        in  2   memop[1:0] of the live request (00 B, 01 H, 10 W)
//   i_wdata       in  32  store data
//   i_ld_addr_lo  in  2   latched byte offset for load extraction
//   i_ld_memop    in  3   latched memop for load extraction
//   i_bus_rdata   in  32  read word from the bus
//   o_be          out 4   byte enables
//   o_lane_wdata  out 32  lane-replicated store data
//   o_rdata_ext   out 32  selected and extended load data
//   o_misalign    out 1   halfword/word not naturally aligned
module lsu_data_align
  import lsu_bus_bridge_pkg::*;
(
  input  logic [1:0]  i_addr_lo,
  input  logic [1:0]  i_size,
  input  logic [31:0] i_wdata,
  input  logic [1:0]  i_ld_addr_lo,
  input  logic [2:0]  i_ld_memop,
  input  logic [31:0] i_bus_rdata,
  output logic [3:0]  o_be,
  output logic [31:0] o_lane_wdata,
  output logic [31:0] o_rdata_ext,
  output logic        o_misalign
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    o_be         = 4'b1111;
    o_lane_wdata = i_wdata;
    o_misalign   = 1'b0;
    case (i_size)
      2'b00: begin
        o_be         = 4'b0001 << i_addr_lo;
        o_lane_wdata = {4{i_wdata[7:0]}};
      end
      2'b01: begin
        o_be         = i_addr_lo[1] ? 4'b1100 : 4'b0011;
        o_lane_wdata = {2{i_wdata[15:0]}};
        o_misalign   = i_addr_lo[0];
      end
      2'b10: o_misalign = |i_addr_lo;
      default: ;
    endcase
  end

  always_comb begin
    case (i_ld_addr_lo)
      2'd0:    w_byte = i_bus_rdata[7:0];
      2'd1:    w_byte = i_bus_rdata[15:8];
      2'd2:    w_byte = i_bus_rdata[23:16];
      default: w_byte = i_bus_rdata[31:24];
    endcase
    w_half = i_ld_addr_lo[1] ? i_bus_rdata[31:16] : i_bus_rdata[15:0];
  end

  always_comb begin
    case (i_ld_memop)
      MEM_OP_B:  o_rdata_ext = {{24{w_byte[7]}}, w_byte};
      MEM_OP_H:  o_rdata_ext = {{16{w_half[15]}}, w_half};
      MEM_OP_BU: o_rdata_ext = {24'd0, w_byte};
      MEM_OP_HU: o_rdata_ext = {16'd0, w_half};
      default:   o_rdata_ext = i_bus_rdata;
    endcase
  end

endmodule

// File: rtl/lsu_bus_bridge.sv
// Load/store unit bus bridge: turns decoder memread/memwrite/memop plus the ALU
// address into a stalling req/ack data-bus transaction (IDLE -> REQ -> DONE).
// Ports:
//   clk, rstn                 clock, asynchronous active-low reset
//   memread, memwrite, memop  access request from the decoder
//   addr, wdata               byte address and store data
//   rdata                     extended load result, valid in the DONE cycle
//   stall                     combinational datapath hold
//   fault                     one-cycle pulse in DONE on any aborted/failed access
//   bus_req/we/addr/be/wdata  registered bus request
//   bus_ack/rdata/err         bus response
module lsu_bus_bridge
  import lsu_bus_bridge_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int CNT_W          = 7
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        memread,
  input  logic        memwrite,
  input  logic [2:0]  memop,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        stall,
  output logic        fault,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata,
  input  logic        bus_err
);

  lsu_state_e       r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [1:0]       r_addr_lo;
  logic [2:0]       r_memop;

  logic        w_acc, w_legal, w_timeout, w_misalign;
  logic [3:0]  w_be;
  logic [31:0] w_lane_wdata, w_rdata_ext;

  assign w_acc     = memread | memwrite;
  assign w_legal   = memop_legal(memop, memwrite) & ~w_misalign;
  assign w_timeout = (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  lsu_data_align u_align (
    .i_addr_lo    (addr[1:0]),
    .i_size       (memop[1:0]),
    .i_wdata      (wdata),
    .i_ld_addr_lo (r_addr_lo),
    .i_ld_memop   (r_memop),
    .i_bus_rdata  (bus_rdata),
    .o_be         (w_be),
    .o_lane_wdata (w_lane_wdata),
    .o_rdata_ext  (w_rdata_ext),
    .o_misalign   (w_misalign)
  );

  // Illegal accesses skip the bus and never stall: the instruction commits in
  // IDLE and the fault pulse follows in DONE.
  always_comb begin
    w_state_nxt = r_state;
    stall       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        stall = w_acc & w_legal;
        if (w_acc) w_state_nxt = w_legal ? ST_REQ : ST_DONE;
      end
      ST_REQ: begin
        stall = 1'b1;
        if (bus_ack || w_timeout) w_state_nxt = ST_DONE;
      end
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      rdata     <= '0;
      fault     <= 1'b0;
      bus_req   <= 1'b0;
      bus_we    <= 1'b0;
      bus_addr  <= '0;
      bus_be    <= '0;
      bus_wdata <= '0;
    end else begin
      r_state <= w_state_nxt;
      fault   <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_cnt <= '0;
          if (w_acc && w_legal) begin
            bus_req   <= 1'b1;
            bus_we    <= memwrite;
            bus_addr  <= {addr[31:2], 2'b00};
            bus_be    <= w_be;
            bus_wdata <= w_lane_wdata;
          end else if (w_acc) begin
            fault <= 1'b1;
            rdata <= '0;
          end
        end
        ST_REQ: begin
          if (bus_ack) begin
            bus_req <= 1'b0;
            rdata   <= (bus_we || bus_err) ? 32'd0 : w_rdata_ext;
            fault   <= bus_err;
          end else if (w_timeout) begin
            bus_req <= 1'b0;
            fault   <= 1'b1;
            rdata   <= '0;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        ST_DONE: r_cnt <= '0;
        default: ;
      endcase
    end
  end

  // Lane/size selectors for load extraction, captured with the request.
  always_ff @(posedge clk) begin
    if (r_state == ST_IDLE && w_acc) begin
      r_addr_lo <= addr[1:0];
      r_memop   <= memop;
    end
  end

endmodule

// File: tb/tb_lsu_bus_bridge.sv
module tb_lsu_bus_bridge;

  localparam int TO = 64;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        memread = 1'b0, memwrite = 1'b0;
  logic [2:0]  memop = 3'b000;
  logic [31:0] addr = '0, wdata = '0;
  logic [31:0] rdata;
  logic        stall, fault;
  logic        bus_req, bus_we;
  logic [31:0] bus_addr, bus_wdata;
  logic [3:0]  bus_be;
  logic        bus_ack = 1'b0;
  logic [31:0] bus_rdata = '0;
  logic        bus_err = 1'b0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  lsu_bus_bridge #(.TIMEOUT_CYCLES(TO), .CNT_W(7)) dut (
    .clk(clk), .rstn(rstn),
    .memread(memread), .memwrite(memwrite), .memop(memop),
    .addr(addr), .wdata(wdata),
    .rdata(rdata), .stall(stall), .fault(fault),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_be(bus_be), .bus_wdata(bus_wdata),
    .bus_ack(bus_ack), .bus_rdata(bus_rdata), .bus_err(bus_err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic rd, input logic wr, input logic [2:0] op,
                       input logic [31:0] a, input logic [31:0] wd);
    memread = rd; memwrite = wr; memop = op; addr = a; wdata = wd;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    tick(); tick();
    checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL rst_rdata got %h want 0", rdata); end
    checks++; if (fault !== 1'b0) begin errors++; $display("FAIL rst_fault got %b want 0", fault); end
    checks++; if (bus_req !== 1'b0) begin errors++; $display("FAIL rst_req got %b want 0", bus_req); end
    checks++; if (bus_we !== 1'b0) begin errors++; $display("FAIL rst_we got %b want 0", bus_we); end
    checks++; if (bus_addr !== 32'h0) begin errors++; $display("FAIL rst_addr got %h want 0", bus_addr); end
    checks++; if (bus_be !== 4'h0) begin errors++; $display("FAIL rst_be got %b want 0", bus_be); end
    checks++; if (bus_wdata !== 32'h0) begin errors++; $display("FAIL rst_wdata got %h want 0", bus_wdata); end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL rst_stall got %b want 0", stall); end
    rstn = 1'b1;
    tick();
  endtask

  task automatic test_store();
    logic [2:0]  op [3] = '{3'b000, 3'b001, 3'b010};
    logic [31:0] a  [3] = '{32'h103, 32'h102, 32'h8};
    logic [31:0] wd [3] = '{32'h000000A5, 32'h00001234, 32'hCAFEF00D};
    logic [3:0]  be [3] = '{4'b1000, 4'b1100, 4'b1111};
    logic [31:0] lw [3] = '{32'hA5A5A5A5, 32'h12341234, 32'hCAFEF00D};
    logic [31:0] wa [3] = '{32'h100, 32'h100, 32'h8};
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b1, op[i], a[i], wd[i]);
      #1;
      checks++; if (stall !== 1'b1) begin errors++; $display("FAIL st%0d_stall_idle got %b want 1", i, stall); end
      tick();
      // inputs wander during REQ; latched copies must be used
      addr = 32'hFFFF_FFFF; wdata = 32'h0;
      checks++; if (bus_req !== 1'b1) begin errors++; $display("FAIL st%0d_req got %b want 1", i, bus_req); end
      checks++; if (bus_we !== 1'b1) begin errors++; $display("FAIL st%0d_we got %b want 1", i, bus_we); end
      checks++; if (bus_addr !== wa[i]) begin errors++; $display("FAIL st%0d_addr got %h want %h", i, bus_addr, wa[i]); end
      checks++; if (bus_be !== be[i]) begin errors++; $display("FAIL st%0d_be got %b want %b", i, bus_be, be[i]); end
      checks++; if (bus_wdata !== lw[i]) begin errors++; $display("FAIL st%0d_wdata got %h want %h", i, bus_wdata, lw[i]); end
      checks++; if (stall !== 1'b1) begin errors++; $display("FAIL st%0d_stall_req got %b want 1", i, stall); end
      bus_ack = 1'b1;
      tick();
      bus_ack = 1'b0;
      checks++; if (bus_req !== 1'b0) begin errors++; $display("FAIL st%0d_req_done got %b want 0", i, bus_req); end
      checks++; if (stall !== 1'b0) begin errors++; $display("FAIL st%0d_stall_done got %b want 0", i, stall); end
      checks++; if (fault !== 1'b0) begin errors++; $display("FAIL st%0d_fault got %b want 0", i, fault); end
      drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
      tick();
    end
  endtask

  task automatic test_load_extend();
    logic [2:0]  op [6] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b010, 3'b000};
    logic [31:0] a  [6] = '{32'h2, 32'h2, 32'h2, 32'h2, 32'h4, 32'h1};
    logic [31:0] rd [6] = '{32'h00800000, 32'h00800000, 32'h80010000, 32'h80010000, 32'hDEADBEEF, 32'h00007F00};
    logic [31:0] ex [6] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF8001, 32'h00008001, 32'hDEADBEEF, 32'h0000007F};
    logic [3:0]  be [6] = '{4'b0100, 4'b0100, 4'b1100, 4'b1100, 4'b1111, 4'b0010};
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 1'b0, op[i], a[i], 32'h0);
      tick();
      addr = a[i] ^ 32'h3; memop = 3'b010;
      checks++; if (bus_we !== 1'b0) begin errors++; $display("FAIL ld%0d_we got %b want 0", i, bus_we); end
      checks++; if (bus_be !== be[i]) begin errors++; $display("FAIL ld%0d_be got %b want %b", i, bus_be, be[i]); end
      bus_rdata = rd[i]; bus_ack = 1'b1;
      tick();
      bus_ack = 1'b0; bus_rdata = 32'h0;
      checks++; if (rdata !== ex[i]) begin errors++; $display("FAIL ld%0d_rdata got %h want %h", i, rdata, ex[i]); end
      checks++; if (fault !== 1'b0) begin errors++; $display("FAIL ld%0d_fault got %b want 0", i, fault); end
      drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
      tick();
    end
  endtask

  task automatic test_bus_err();
    // load with error: data discarded, fault pulse
    drive(1'b1, 1'b0, 3'b010, 32'h40, 32'h0);
    tick();
    bus_ack = 1'b1; bus_err = 1'b1; bus_rdata = 32'hFFFF_FFFF;
    tick();
    bus_ack = 1'b0; bus_err = 1'b0; bus_rdata = 32'h0;
    checks++; if (fault !== 1'b1) begin errors++; $display("FAIL lderr_fault got %b want 1", fault); end
    checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL lderr_rdata got %h want 0", rdata); end
    drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    tick();
    checks++; if (fault !== 1'b0) begin errors++; $display("FAIL lderr_fault_clr got %b want 0", fault); end
    // store with error
    drive(1'b0, 1'b1, 3'b010, 32'h44, 32'h1);
    tick();
    bus_ack = 1'b1; bus_err = 1'b1;
    tick();
    bus_ack = 1'b0; bus_err = 1'b0;
    checks++; if (fault !== 1'b1) begin errors++; $display("FAIL sterr_fault got %b want 1", fault); end
    checks++; if (bus_req !== 1'b0) begin errors++; $display("FAIL sterr_req got %b want 0", bus_req); end
    drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    tick();
    checks++; if (fault !== 1'b0) begin errors++; $display("FAIL sterr_fault_clr got %b want 0", fault); end
  endtask

  task automatic test_back_to_back();
    // LW
    drive(1'b1, 1'b0, 3'b010, 32'h20, 32'h0);
    #1;
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL b2b_lw_stall0 got %b want 1", stall); end
    tick();
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL b2b_lw_stall1 got %b want 1", stall); end
    bus_ack = 1'b1; bus_rdata = 32'h11223344;
    tick();
    bus_ack = 1'b0; bus_rdata = 32'h0;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL b2b_lw_stall2 got %b want 0", stall); end
    checks++; if (rdata !== 32'h11223344) begin errors++; $display("FAIL b2b_lw_rdata got %h want 11223344", rdata); end
    tick();
    // SW
    drive(1'b0, 1'b1, 3'b010, 32'h24, 32'h55667788);
    tick();
    checks++; if (bus_req !== 1'b1 || bus_we !== 1'b1) begin errors++; $display("FAIL b2b_sw_req got %b%b want 11", bus_req, bus_we); end
    checks++; if (bus_wdata !== 32'h55667788) begin errors++; $display("FAIL b2b_sw_wdata got %h want 55667788", bus_wdata); end
    bus_ack = 1'b1;
    tick();
    bus_ack = 1'b0;
    checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL b2b_sw_rdata got %h want 0", rdata); end
    tick();
    // add: no memory access, spurious ack
    drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    bus_ack = 1'b1; bus_rdata = 32'hBAD0BAD0;
    #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL b2b_add_stall got %b want 0", stall); end
    tick();
    bus_ack = 1'b0; bus_rdata = 32'h0;
    checks++; if (bus_req !== 1'b0) begin errors++; $display("FAIL b2b_spur_req got %b want 0", bus_req); end
    checks++; if (fault !== 1'b0) begin errors++; $display("FAIL b2b_spur_fault got %b want 0", fault); end
    checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL b2b_spur_rdata got %h want 0", rdata); end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL b2b_spur_stall got %b want 0", stall); end
    // trailing LW leaves a non-zero result behind
    drive(1'b1, 1'b0, 3'b010, 32'h28, 32'h0);
    tick();
    bus_ack = 1'b1; bus_rdata = 32'hCAFE0001;
    tick();
    bus_ack = 1'b0; bus_rdata = 32'h0;
    checks++; if (rdata !== 32'hCAFE0001) begin errors++; $display("FAIL b2b_lw2_rdata got %h want cafe0001", rdata); end
    drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    tick();
  endtask

  task automatic test_misaligned();
    logic        rd [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
    logic [2:0]  op [4] = '{3'b001, 3'b011, 3'b100, 3'b010};
    logic [31:0] a  [4] = '{32'h1, 32'h0, 32'h0, 32'h2};
    for (int i = 0; i < 4; i++) begin
      drive(rd[i], ~rd[i], op[i], a[i], 32'h0);
      #1;
      checks++; if (stall !== 1'b0) begin errors++; $display("FAIL ill%0d_stall got %b want 0", i, stall); end
      tick();
      checks++; if (fault !== 1'b1) begin errors++; $display("FAIL ill%0d_fault got %b want 1", i, fault); end
      checks++; if (bus_req !== 1'b0) begin errors++; $display("FAIL ill%0d_req got %b want 0", i, bus_req); end
      checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL ill%0d_rdata got %h want 0", i, rdata); end
      checks++; if (stall !== 1'b0) begin errors++; $display("FAIL ill%0d_stall_done got %b want 0", i, stall); end
      drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
      tick();
      checks++; if (fault !== 1'b0 || bus_req !== 1'b0) begin errors++; $display("FAIL ill%0d_after got %b%b want 00", i, fault, bus_req); end
    end
  endtask

  task automatic test_timeout();
    drive(1'b1, 1'b0, 3'b010, 32'h30, 32'h0);
    tick();
    checks++; if (bus_req !== 1'b1) begin errors++; $display("FAIL to_req_start got %b want 1", bus_req); end
    repeat (TO - 1) tick();
    checks++; if (bus_req !== 1'b1 || fault !== 1'b0 || stall !== 1'b1) begin
      errors++; $display("FAIL to_last_req got req=%b fault=%b stall=%b want 1 0 1", bus_req, fault, stall);
    end
    tick();
    checks++; if (bus_req !== 1'b0) begin errors++; $display("FAIL to_req_drop got %b want 0", bus_req); end
    checks++; if (fault !== 1'b1) begin errors++; $display("FAIL to_fault got %b want 1", fault); end
    checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL to_rdata got %h want 0", rdata); end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL to_stall got %b want 0", stall); end
    drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    tick();
    checks++; if (fault !== 1'b0) begin errors++; $display("FAIL to_fault_clr got %b want 0", fault); end
  endtask

  task automatic test_reset_mid();
    drive(1'b1, 1'b0, 3'b010, 32'h50, 32'h0);
    tick();
    checks++; if (bus_req !== 1'b1) begin errors++; $display("FAIL rmid_req got %b want 1", bus_req); end
    drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    #2 rstn = 1'b0;
    #1;
    checks++; if (bus_req !== 1'b0) begin errors++; $display("FAIL rmid_req_async got %b want 0", bus_req); end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL rmid_stall got %b want 0", stall); end
    #2 rstn = 1'b1;
    tick();
    checks++; if (bus_req !== 1'b0 || stall !== 1'b0 || fault !== 1'b0) begin
      errors++; $display("FAIL rmid_after got req=%b stall=%b fault=%b want 0 0 0", bus_req, stall, fault);
    end
  endtask

  initial begin
    test_reset();
    test_store();
    test_load_extend();
    test_misaligned();
    test_bus_err();
    test_back_to_back();
    test_timeout();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
